// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle control unit:
// FSM states, opcode constants, instruction classes and mux selects.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        TRAP    = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JUMP,
        CL_ILLEGAL
    } op_class_t;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JAL    = 2'd2;
    localparam logic [1:0] PC_JALR   = 2'd3;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;
    localparam logic [1:0] WB_IMMU = 2'd3;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode decode: opcode -> imm_sel, wb_sel, alu_src_b, class.
// Unknown opcodes report CL_ILLEGAL.
module opcode_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] imm_sel,
    output logic [1:0] wb_sel,
    output logic       alu_src_b,
    output op_class_t  op_class
);

    always_comb begin
        imm_sel   = IMM_NONE;
        wb_sel    = WB_ALU;
        alu_src_b = 1'b1;
        op_class  = CL_ALU;
        unique case (1'b1)
            (opcode == OP_OP): begin
                alu_src_b = 1'b0;
            end
            (opcode == OP_IMM): begin
                imm_sel = IMM_I;
            end
            (opcode == OP_LOAD): begin
                imm_sel  = IMM_I;
                wb_sel   = WB_MEM;
                op_class = CL_LOAD;
            end
            (opcode == OP_STORE): begin
                imm_sel  = IMM_S;
                op_class = CL_STORE;
            end
            (opcode == OP_BRANCH): begin
                imm_sel   = IMM_B;
                alu_src_b = 1'b0;
                op_class  = CL_BRANCH;
            end
            (opcode == OP_JAL): begin
                imm_sel  = IMM_J;
                wb_sel   = WB_PC4;
                op_class = CL_JUMP;
            end
            (opcode == OP_JALR): begin
                imm_sel  = IMM_I;
                wb_sel   = WB_PC4;
                op_class = CL_JUMP;
            end
            (opcode == OP_LUI): begin
                imm_sel = IMM_U;
                wb_sel  = WB_IMMU;
            end
            (opcode == OP_AUIPC): begin
                imm_sel = IMM_U;
            end
            default: begin
                alu_src_b = 1'b0;
                op_class  = CL_ILLEGAL;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM/WB plus sticky TRAP.
// Ports: clk, rst_n, inst, mem_ack, branch_taken in; memory, PC, WB controls out.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic        mem_ack,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic [31:0] ir,
    output logic [6:0]  opcode,
    output logic [2:0]  imm_sel,
    output logic        alu_src_b,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic [31:0] pc_init,
    output logic [2:0]  state,
    output logic        trap,
    output logic        trap_cause
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

    state_t        st;
    op_class_t     cls;
    logic          pc_we_q;
    logic [CW-1:0] wait_cnt;
    logic          hs;
    logic          stall;
    logic          expire;
    logic          store_done;

    // Decode straight off ir: it only changes on a fetch handshake,
    // so the selects hold for the whole instruction.
    opcode_decoder u_dec (
        .opcode    (opcode),
        .imm_sel   (imm_sel),
        .wb_sel    (wb_sel),
        .alu_src_b (alu_src_b),
        .op_class  (cls)
    );

    assign opcode  = ir[6:0];
    assign pc_init = RESET_PC;
    assign state   = st;

    assign hs     = mem_req & mem_ack;
    assign stall  = mem_req & ~mem_ack;
    assign expire = stall && (wait_cnt == WAIT_LAST);

    // Store completes in the ack cycle itself, so its PC bump
    // cannot wait for a register stage.
    assign store_done = (st == MEM) && mem_we && hs;
    assign pc_we      = pc_we_q | store_done;

    always_comb begin
        pc_src = PC_PLUS4;
        if (st == EXECUTE && cls == CL_BRANCH) begin
            pc_src = branch_taken ? PC_BRANCH : PC_PLUS4;
        end else if (st == WB && cls == CL_JUMP) begin
            pc_src = (imm_sel == IMM_J) ? PC_JAL : PC_JALR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= FETCH;
            ir         <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            addr_sel   <= 1'b0;
            reg_we     <= 1'b0;
            pc_we_q    <= 1'b0;
            trap       <= 1'b0;
            trap_cause <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            reg_we   <= 1'b0;
            pc_we_q  <= 1'b0;
            wait_cnt <= (stall && !expire) ? wait_cnt + 1'b1 : '0;
            unique case (st)
                FETCH: begin
                    if (expire) begin
                        st         <= TRAP;
                        mem_req    <= 1'b0;
                        trap       <= 1'b1;
                        trap_cause <= 1'b1;
                    end else if (hs) begin
                        ir      <= inst;
                        mem_req <= 1'b0;
                        st      <= DECODE;
                    end else begin
                        mem_req <= 1'b1;
                    end
                end
                DECODE: begin
                    if (cls == CL_ILLEGAL) begin
                        st         <= TRAP;
                        trap       <= 1'b1;
                        trap_cause <= 1'b0;
                    end else begin
                        st      <= EXECUTE;
                        pc_we_q <= (cls == CL_BRANCH);
                    end
                end
                EXECUTE: begin
                    unique case (1'b1)
                        (cls == CL_BRANCH): begin
                            st      <= FETCH;
                            mem_req <= 1'b1;
                        end
                        (cls == CL_LOAD || cls == CL_STORE): begin
                            st       <= MEM;
                            mem_req  <= 1'b1;
                            addr_sel <= 1'b1;
                            mem_we   <= (cls == CL_STORE);
                        end
                        default: begin
                            st      <= WB;
                            reg_we  <= 1'b1;
                            pc_we_q <= 1'b1;
                        end
                    endcase
                end
                MEM: begin
                    if (expire) begin
                        st         <= TRAP;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        addr_sel   <= 1'b0;
                        trap       <= 1'b1;
                        trap_cause <= 1'b1;
                    end else if (hs) begin
                        mem_we   <= 1'b0;
                        addr_sel <= 1'b0;
                        if (mem_we) begin
                            st <= FETCH;
                        end else begin
                            st      <= WB;
                            mem_req <= 1'b0;
                            reg_we  <= 1'b1;
                            pc_we_q <= 1'b1;
                        end
                    end
                end
                WB: begin
                    st      <= FETCH;
                    mem_req <= 1'b1;
                end
                TRAP: begin
                    mem_req  <= 1'b0;
                    mem_we   <= 1'b0;
                    addr_sel <= 1'b0;
                end
                default: begin
                    st <= TRAP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller:
// vector table, random instructions vs model, trap/reset sequences.
module tb_multicycle_controller;
    import riscv_ctrl_pkg::*;

    typedef struct {
        int         cyc;
        int         nreg;
        int         npc;
        logic [1:0] wbs;
        logic [1:0] pcs;
        logic [2:0] imm;
        int         nmreq;
        int         nmwe;
        int         nasel;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        logic        bt;
        int          f;
        int          m;
        exp_t        e;
    } vec_t;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst = '0;
    logic        mem_ack = 1'b0;
    logic        branch_taken = 1'b0;
    logic        mem_req, mem_we, addr_sel, alu_src_b;
    logic [31:0] ir, pc_init;
    logic [6:0]  opcode;
    logic [2:0]  imm_sel, state;
    logic        pc_we, reg_we, trap, trap_cause;
    logic [1:0]  pc_src, wb_sel;

    int   total = 0;
    int   bad = 0;
    vec_t vecs[13];
    logic [6:0] ops[9];

    multicycle_controller #(
        .RESET_PC    (RST_PC),
        .MEM_TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst         (inst),
        .mem_ack      (mem_ack),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .addr_sel     (addr_sel),
        .ir           (ir),
        .opcode       (opcode),
        .imm_sel      (imm_sel),
        .alu_src_b    (alu_src_b),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .pc_init      (pc_init),
        .state        (state),
        .trap         (trap),
        .trap_cause   (trap_cause)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Expected per-instruction behaviour from the ISA-level rules.
    function automatic exp_t model(input logic [6:0] op, input logic bt,
                                   input int f, input int m);
        exp_t e;
        e = '{cyc: 4 + f, nreg: 1, npc: 1, wbs: 2'd0, pcs: 2'd0,
              imm: 3'd1, nmreq: 1 + f, nmwe: 0, nasel: 0};
        case (op)
            7'b0110011: e.imm = 3'd0;
            7'b0000011: begin
                e.cyc = 5 + f + m; e.wbs = 2'd1;
                e.nmreq = 2 + f + m; e.nasel = 1 + m;
            end
            7'b0100011: begin
                e.cyc = 4 + f + m; e.nreg = 0; e.imm = 3'd2;
                e.nmreq = 2 + f + m; e.nmwe = 1 + m; e.nasel = 1 + m;
            end
            7'b1100011: begin
                e.cyc = 3 + f; e.nreg = 0; e.imm = 3'd3;
                e.pcs = {1'b0, bt};
            end
            7'b1101111: begin e.wbs = 2'd2; e.pcs = 2'd2; e.imm = 3'd5; end
            7'b1100111: begin e.wbs = 2'd2; e.pcs = 2'd3; end
            7'b0110111: begin e.wbs = 2'd3; e.imm = 3'd4; end
            7'b0010111: e.imm = 3'd4;
            default: ;
        endcase
        return e;
    endfunction

    task automatic tick(input logic a, input logic b);
        @(negedge clk);
        mem_ack = a;
        branch_taken = b;
        #1;
    endtask

    task automatic expect_fetch(input string nm);
        @(posedge clk);
        #1;
        chk({nm, ".fetch_state"}, state, FETCH);
        chk({nm, ".fetch_req"}, mem_req, 1);
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst_n = 1'b0;
        mem_ack = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        expect_fetch(nm);
    endtask

    // Runs one instruction with f fetch waits and m data waits;
    // a memory responder reacts to mem_req, spurious acks otherwise.
    task automatic run_instr(input string nm, input logic [31:0] ins,
                             input logic bt, input int f, input int m,
                             input exp_t e);
        int w, nmreq, nmwe, nasel, nreg, npc, unst;
        logic [1:0] wbs, pcs;
        logic [2:0] imm;
        logic a, asrc;
        w = f; nmreq = 0; nmwe = 0; nasel = 0;
        nreg = 0; npc = 0; unst = 0;
        wbs = 2'd0; pcs = 2'd0; imm = 3'd7;
        asrc = (e.imm == 3'd1) || (e.imm == 3'd2) ||
               (e.imm == 3'd4) || (e.imm == 3'd5);
        inst = ins;
        for (int c = 0; c < e.cyc; c++) begin
            @(negedge clk);
            a = 1'b0;
            if (mem_req) begin
                if (w == 0) begin a = 1'b1; w = m; end
                else w--;
            end else begin
                a = ($urandom_range(0, 3) == 0);
            end
            mem_ack = a;
            branch_taken = bt;
            #1;
            if (mem_req) nmreq++;
            if (mem_we) nmwe++;
            if (addr_sel) nasel++;
            if (reg_we) begin nreg++; wbs = wb_sel; end
            if (pc_we) begin npc++; pcs = pc_src; end
            if (state == DECODE) imm = imm_sel;
            if (state != FETCH &&
                (imm_sel !== e.imm || alu_src_b !== asrc)) unst++;
        end
        @(posedge clk);
        #1;
        chk({nm, ".end_state"}, state, FETCH);
        chk({nm, ".end_req"}, mem_req, 1);
        chk({nm, ".ir"}, ir, ins);
        chk({nm, ".opcode"}, opcode, ins[6:0]);
        chk({nm, ".imm_sel"}, imm, e.imm);
        chk({nm, ".sel_stable"}, unst, 0);
        chk({nm, ".reg_we_cnt"}, nreg, e.nreg);
        chk({nm, ".pc_we_cnt"}, npc, e.npc);
        chk({nm, ".pc_src"}, pcs, e.pcs);
        if (e.nreg > 0) chk({nm, ".wb_sel"}, wbs, e.wbs);
        chk({nm, ".mem_req_cnt"}, nmreq, e.nmreq);
        chk({nm, ".mem_we_cnt"}, nmwe, e.nmwe);
        chk({nm, ".addr_sel_cnt"}, nasel, e.nasel);
    endtask

    initial begin
        int n;
        logic [31:0] r;
        logic [6:0] op;
        logic bt;
        int f, m;

        vecs[0]  = '{32'h00500093, 1'b0, 0, 0, '{4, 1, 1, 2'd0, 2'd0, 3'd1, 1, 0, 0}};
        vecs[1]  = '{32'h00208463, 1'b1, 0, 0, '{3, 0, 1, 2'd0, 2'd1, 3'd3, 1, 0, 0}};
        vecs[2]  = '{32'h00208463, 1'b0, 0, 0, '{3, 0, 1, 2'd0, 2'd0, 3'd3, 1, 0, 0}};
        vecs[3]  = '{32'h00112223, 1'b0, 0, 0, '{4, 0, 1, 2'd0, 2'd0, 3'd2, 2, 1, 1}};
        vecs[4]  = '{32'h00012083, 1'b0, 0, 0, '{5, 1, 1, 2'd1, 2'd0, 3'd1, 2, 0, 1}};
        vecs[5]  = '{32'h00012083, 1'b0, 0, 2, '{7, 1, 1, 2'd1, 2'd0, 3'd1, 4, 0, 3}};
        vecs[6]  = '{32'h0080006F, 1'b0, 0, 0, '{4, 1, 1, 2'd2, 2'd2, 3'd5, 1, 0, 0}};
        vecs[7]  = '{32'h000080E7, 1'b0, 0, 0, '{4, 1, 1, 2'd2, 2'd3, 3'd1, 1, 0, 0}};
        vecs[8]  = '{32'h123450B7, 1'b0, 0, 0, '{4, 1, 1, 2'd3, 2'd0, 3'd4, 1, 0, 0}};
        vecs[9]  = '{32'h00001097, 1'b0, 0, 0, '{4, 1, 1, 2'd0, 2'd0, 3'd4, 1, 0, 0}};
        vecs[10] = '{32'h002081B3, 1'b0, 0, 0, '{4, 1, 1, 2'd0, 2'd0, 3'd0, 1, 0, 0}};
        vecs[11] = '{32'h00500093, 1'b0, 2, 0, '{6, 1, 1, 2'd0, 2'd0, 3'd1, 3, 0, 0}};
        vecs[12] = '{32'h00112223, 1'b0, 1, 3, '{8, 0, 1, 2'd0, 2'd0, 3'd2, 6, 4, 4}};

        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

        // reset state
        #3;
        chk("rst.state", state, FETCH);
        chk("rst.ir", ir, 0);
        chk("rst.trap", trap, 0);
        chk("rst.cause", trap_cause, 0);
        chk("rst.mem_req", mem_req, 0);
        chk("rst.mem_we", mem_we, 0);
        chk("rst.addr_sel", addr_sel, 0);
        chk("rst.pc_we", pc_we, 0);
        chk("rst.reg_we", reg_we, 0);
        chk("rst.pc_init", pc_init, RST_PC);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("boot.req_low", mem_req, 0);
        expect_fetch("boot");

        foreach (vecs[i]) begin
            run_instr($sformatf("vec%0d", i), vecs[i].ins, vecs[i].bt,
                      vecs[i].f, vecs[i].m, vecs[i].e);
        end

        for (int i = 0; i < 60; i++) begin
            r  = $urandom;
            op = ops[$urandom_range(0, 8)];
            bt = 1'($urandom_range(0, 1));
            f  = $urandom_range(0, 3);
            m  = $urandom_range(0, 3);
            run_instr($sformatf("rnd%0d", i), {r[31:7], op}, bt, f, m,
                      model(op, bt, f, m));
        end

        // reset while a store sits in MEM
        inst = 32'h00112223;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("rstmem.in_mem_we", mem_we, 1);
        #2;
        rst_n = 1'b0;
        mem_ack = 1'b1;
        #1;
        chk("rstmem.state", state, FETCH);
        chk("rstmem.mem_req", mem_req, 0);
        chk("rstmem.mem_we", mem_we, 0);
        chk("rstmem.pc_we", pc_we, 0);
        chk("rstmem.reg_we", reg_we, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rstmem.rel_pc_we", pc_we, 0);
        chk("rstmem.rel_reg_we", reg_we, 0);
        chk("rstmem.rel_req", mem_req, 0);
        expect_fetch("rstmem");
        chk("rstmem.ack_ignored", ir, 0);
        run_instr("rstmem.addi", 32'h00500093, 1'b0, 0, 0,
                  model(7'b0010011, 1'b0, 0, 0));

        // illegal opcode
        inst = 32'hFFFF_FFFF;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("ill.state", state, TRAP);
        chk("ill.trap", trap, 1);
        chk("ill.cause", trap_cause, 0);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (mem_req || pc_we || reg_we) n++;
        end
        chk("ill.quiet", n, 0);
        chk("ill.stay", state, TRAP);
        chk("ill.sticky", trap, 1);
        do_reset("ill.rst");

        // fetch timeout: 15 stalls survive, the 16th traps
        for (int k = 0; k < 15; k++) tick(1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("tmo.trap_at_15", trap, 0);
        chk("tmo.req_at_15", mem_req, 1);
        tick(1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("tmo.trap", trap, 1);
        chk("tmo.cause", trap_cause, 1);
        chk("tmo.state", state, TRAP);
        chk("tmo.req", mem_req, 0);
        do_reset("tmo.rst");
        chk("tmo.rst_trap", trap, 0);
        run_instr("tmo.lw", 32'h00012083, 1'b0, 0, 1,
                  model(7'b0000011, 1'b0, 0, 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
